// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control path: FSM states, opcodes,
// funct codes, ALU control values and the per-state control word.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_RSVD  = 2'b11
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      aluop_t     aluop;
      logic       done;
   } ctrl_t;

   // Moore control word for each state; unlisted encodings give all zeros.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   begin c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1; end
         S_DECODE:  c.alu_src_b = 2'b11;
         S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
         S_EXECUTE: begin c.alu_src_a = 1'b1; c.aluop = ALUOP_FUNCT; end
         S_ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.done = 1'b1; end
         S_BRANCH:  begin
            c.alu_src_a = 1'b1; c.aluop = ALUOP_SUB; c.pc_src = 2'b01;
            c.branch = 1'b1; c.done = 1'b1;
         end
         S_ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
         S_ADDIWB:  begin c.reg_write = 1'b1; c.done = 1'b1; end
         S_JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.done = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// Combinational ALU decoder shared by the single- and multi-cycle controllers.
module aludec
   import mips_pkg::*;
(
   input  logic [5:0] funct_i6,
   input  aluop_t     aluop_i2,
   output logic [2:0] alu_control_o3
);

   // Map aluop (and funct for R-type) onto the ALU operation code.
   always_comb begin
      alu_control_o3 = ALU_ADD;
      case (aluop_i2)
         ALUOP_SUB: alu_control_o3 = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i6)
               F_ADD:   alu_control_o3 = ALU_ADD;
               F_SUB:   alu_control_o3 = ALU_SUB;
               F_AND:   alu_control_o3 = ALU_AND;
               F_OR:    alu_control_o3 = ALU_OR;
               F_SLT:   alu_control_o3 = ALU_SLT;
               default: alu_control_o3 = ALU_ADD;
            endcase
         end
         default: alu_control_o3 = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// plus the shared ALU decoder.
module mips_mc_controller
   import mips_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [5:0] opcode_i6,
   input  logic [5:0] funct_i6,
   input  logic       zero_i,
   output logic       iord_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       pc_en_o,
   output logic       reg_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o2,
   output logic [1:0] pc_src_o2,
   output logic [2:0] alu_control_o3,
   output logic       instr_done_o,
   output logic       illegal_o,
   output logic [3:0] state_o4
);

   state_t state, next_state;
   ctrl_t  ctrl;
   logic   op_legal;

   // Opcodes the decoder knows how to sequence.
   always_comb begin
      op_legal = 1'b0;
      case (opcode_i6)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   // Next-state selection; anything unexpected falls back to FETCH.
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (opcode_i6)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXECUTE;
               OP_BEQ:       next_state = S_BRANCH;
               OP_ADDI:      next_state = S_ADDIEX;
               OP_J:         next_state = S_JUMP;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR:  next_state = (opcode_i6 == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   next_state = S_MEMWB;
         S_EXECUTE: next_state = S_ALUWB;
         S_ADDIEX:  next_state = S_ADDIWB;
         default:   next_state = S_FETCH;
      endcase
   end

   // State register; the control word is registered alongside the state
   // from the same next-state value, so it always matches state_o4.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= S_FETCH;
         ctrl  <= state_ctrl(S_FETCH);
      end else begin
         state <= next_state;
         ctrl  <= state_ctrl(next_state);
      end
   end

   aludec u_aludec (
      .funct_i6       (funct_i6),
      .aluop_i2       (ctrl.aluop),
      .alu_control_o3 (alu_control_o3)
   );

   assign iord_o       = ctrl.iord;
   assign mem_write_o  = ctrl.mem_write;
   assign ir_write_o   = ctrl.ir_write;
   assign pc_en_o      = ctrl.pc_write | (ctrl.branch & zero_i);
   assign reg_write_o  = ctrl.reg_write;
   assign reg_dst_o    = ctrl.reg_dst;
   assign mem_to_reg_o = ctrl.mem_to_reg;
   assign alu_src_a_o  = ctrl.alu_src_a;
   assign alu_src_b_o2 = ctrl.alu_src_b;
   assign pc_src_o2    = ctrl.pc_src;
   assign instr_done_o = ctrl.done;
   assign illegal_o    = (state == S_DECODE) & ~op_legal;
   assign state_o4     = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: table of instructions with expected state
// sequences, per-cycle expectations queued and compared, plus reset cases.
module tb_mips_mc_controller;

   logic       clk_i = 1'b0;
   logic       reset_ni;
   logic [5:0] opcode_i6;
   logic [5:0] funct_i6;
   logic       zero_i;
   logic       iord_o, mem_write_o, ir_write_o, pc_en_o, reg_write_o;
   logic       reg_dst_o, mem_to_reg_o, alu_src_a_o, instr_done_o, illegal_o;
   logic [1:0] alu_src_b_o2, pc_src_o2;
   logic [2:0] alu_control_o3;
   logic [3:0] state_o4;

   mips_mc_controller dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .opcode_i6(opcode_i6),
      .funct_i6(funct_i6), .zero_i(zero_i), .iord_o(iord_o),
      .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .pc_en_o(pc_en_o),
      .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
      .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
      .alu_src_b_o2(alu_src_b_o2), .pc_src_o2(pc_src_o2),
      .alu_control_o3(alu_control_o3), .instr_done_o(instr_done_o),
      .illegal_o(illegal_o), .state_o4(state_o4)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       pc_en;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
      logic       done;
      logic       illegal;
   } outs_t;

   typedef struct {
      string      tag;
      logic [3:0] st;
      outs_t      o;
   } exp_t;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        zero;
      logic        bad;
      int unsigned len;
      logic [23:0] seq;
   } vec_t;

   outs_t act;
   assign act = {iord_o, mem_write_o, ir_write_o, pc_en_o, reg_write_o,
                 reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o2,
                 pc_src_o2, alu_control_o3, instr_done_o, illegal_o};

   int unsigned checks = 0;
   int unsigned errors = 0;
   exp_t        sbq[$];
   vec_t        vecs[12];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   // Expected outputs for a state, written straight from the state table.
   function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] fn,
                                      input logic z, input logic bad);
      outs_t o;
      o = '0;
      o.alu_control = 3'b010;
      case (st)
         4'd0:  begin o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1; end
         4'd1:  begin o.alu_src_b = 2'b11; o.illegal = bad; end
         4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         4'd3:  o.iord = 1'b1;
         4'd4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.done = 1'b1; end
         4'd5:  begin o.iord = 1'b1; o.mem_write = 1'b1; o.done = 1'b1; end
         4'd6:  begin
            o.alu_src_a = 1'b1;
            case (fn)
               6'b100010: o.alu_control = 3'b110;
               6'b100100: o.alu_control = 3'b000;
               6'b100101: o.alu_control = 3'b001;
               6'b101010: o.alu_control = 3'b111;
               default:   o.alu_control = 3'b010;
            endcase
         end
         4'd7:  begin o.reg_dst = 1'b1; o.reg_write = 1'b1; o.done = 1'b1; end
         4'd8:  begin
            o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01;
            o.pc_en = z; o.done = 1'b1;
         end
         4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         4'd10: begin o.reg_write = 1'b1; o.done = 1'b1; end
         4'd11: begin o.pc_src = 2'b10; o.pc_en = 1'b1; o.done = 1'b1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   // Runs one instruction starting in FETCH, shortly after a rising edge.
   task automatic run_vec(input vec_t v);
      exp_t e;
      opcode_i6 = v.op;
      funct_i6  = v.fn;
      zero_i    = v.zero;
      for (int unsigned k = 0; k < v.len; k++) begin
         e.tag = $sformatf("%s c%0d", v.name, k);
         e.st  = v.seq[4*k +: 4];
         e.o   = exp_outs(e.st, v.fn, v.zero, v.bad);
         sbq.push_back(e);
      end
      for (int unsigned k = 0; k < v.len; k++) begin
         @(negedge clk_i);
         if (sbq.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk({e.tag, " state"}, {28'd0, state_o4}, {28'd0, e.st});
            chk({e.tag, " outs"}, {15'd0, act}, {15'd0, e.o});
         end
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      vecs[0]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 1'b0, 5, 24'h043210};
      vecs[1]  = '{"sw",      6'b101011, 6'b000000, 1'b0, 1'b0, 4, 24'h005210};
      vecs[2]  = '{"add",     6'b000000, 6'b100000, 1'b0, 1'b0, 4, 24'h007610};
      vecs[3]  = '{"sub",     6'b000000, 6'b100010, 1'b1, 1'b0, 4, 24'h007610};
      vecs[4]  = '{"and",     6'b000000, 6'b100100, 1'b0, 1'b0, 4, 24'h007610};
      vecs[5]  = '{"or",      6'b000000, 6'b100101, 1'b0, 1'b0, 4, 24'h007610};
      vecs[6]  = '{"slt",     6'b000000, 6'b101010, 1'b0, 1'b0, 4, 24'h007610};
      vecs[7]  = '{"rbadfn",  6'b000000, 6'b000111, 1'b0, 1'b0, 4, 24'h007610};
      vecs[8]  = '{"addi",    6'b001000, 6'b101010, 1'b0, 1'b0, 4, 24'h00a910};
      vecs[9]  = '{"beq_z1",  6'b000100, 6'b000000, 1'b1, 1'b0, 3, 24'h000810};
      vecs[10] = '{"beq_z0",  6'b000100, 6'b000000, 1'b0, 1'b0, 3, 24'h000810};
      vecs[11] = '{"j",       6'b000010, 6'b000000, 1'b0, 1'b0, 3, 24'h000b10};

      reset_ni  = 1'b0;
      opcode_i6 = 6'b100011;
      funct_i6  = '0;
      zero_i    = 1'b0;

      // Reset held for three cycles: FETCH outputs throughout.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk($sformatf("reset%0d state", i), {28'd0, state_o4}, 32'd0);
         chk($sformatf("reset%0d outs", i), {15'd0, act},
             {15'd0, exp_outs(4'd0, 6'd0, 1'b0, 1'b0)});
      end
      @(posedge clk_i);
      #1 reset_ni = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Unsupported opcode: flagged in DECODE, then straight back to FETCH.
      run_vec('{"illegal", 6'b111111, 6'b000000, 1'b0, 1'b1, 2, 24'h000010});
      run_vec(vecs[11]);

      // zero_i acts combinationally while in BRANCH.
      opcode_i6 = 6'b000100;
      zero_i    = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk("beq_hold state", {28'd0, state_o4}, 32'd8);
      chk("beq_hold pc_en z0", {31'd0, pc_en_o}, 32'd0);
      zero_i = 1'b1;
      #1 chk("beq_hold pc_en z1", {31'd0, pc_en_o}, 32'd1);
      zero_i = 1'b0;
      @(posedge clk_i); #1;
      chk("beq_hold back", {28'd0, state_o4}, 32'd0);

      // Asynchronous reset in the middle of sw's write cycle.
      opcode_i6 = 6'b101011;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      chk("sw_async in MEMWR", {28'd0, state_o4}, 32'd5);
      chk("sw_async mem_write pre", {31'd0, mem_write_o}, 32'd1);
      #2 reset_ni = 1'b0;
      #1;
      chk("sw_async state", {28'd0, state_o4}, 32'd0);
      chk("sw_async mem_write", {31'd0, mem_write_o}, 32'd0);
      chk("sw_async ir_write", {31'd0, ir_write_o}, 32'd1);
      @(posedge clk_i);
      #1 reset_ni = 1'b1;
      @(negedge clk_i);
      chk("post_reset state", {28'd0, state_o4}, 32'd0);
      @(posedge clk_i); #1;
      chk("post_reset decode", {28'd0, state_o4}, 32'd1);
      chk("post_reset no write", {30'd0, mem_write_o, reg_write_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Control unit for the multicycle MIPS core. It sequences one shared memory, one ALU and the PC/IR/register-file datapath across several cycles per instruction. It is a Moore FSM plus a combinational ALU decoder, and it sits inside the multicycle `mips` wrapper next to the datapath. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

Parameters:
None. All encodings are fixed in the shared package.

Ports:
clk_i  in  1  clock, rising-edge
reset_ni  in  1  asynchronous, active-low reset
opcode_i6  in  6  instr[31:26] from the IR
funct_i6  in  6  instr[5:0] from the IR
zero_i  in  1  ALU zero flag
iord_o  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write_o  out  1  memory write strobe
ir_write_o  out  1  IR load enable
pc_en_o  out  1  PC load enable
reg_write_o  out  1  register-file write enable
reg_dst_o  out  1  write-register select: 0 = rt, 1 = rd
mem_to_reg_o  out  1  write-data select: 0 = ALUOut, 1 = Data
alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = A
alu_src_b_o2  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pc_src_o2  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alu_control_o3  out  3  ALU operation code
instr_done_o  out  1  one-cycle pulse in the final state of each instruction
illegal_o  out  1  one-cycle pulse in DECODE when the opcode is unsupported
state_o4  out  4  current state, for debug and the testbench

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- reset_ni low forces the state to FETCH immediately, including mid-instruction. The in-flight instruction is abandoned and no partial write completes after reset deasserts.
- All outputs are decoded from the state (Moore). pc_en_o is the one exception: pc_en_o = pc_write | (branch & zero_i).
- Any output not listed for a state below is 0.
- Output values per state:
  - FETCH (0): alu_src_b=01, aluop=00, ir_write=1, pc_write=1. These are also the output values during reset.
  - DECODE (1): alu_src_b=11, aluop=00.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, aluop=00.
  - MEMRD (3): iord=1.
  - MEMWB (4): mem_to_reg=1, reg_write=1, done.
  - MEMWR (5): iord=1, mem_write=1, done.
  - EXECUTE (6): alu_src_a=1, alu_src_b=00, aluop=10.
  - ALUWB (7): reg_dst=1, reg_write=1, done.
  - BRANCH (8): alu_src_a=1, aluop=01, pc_src=01, branch=1, done.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, aluop=00.
  - ADDIWB (10): reg_write=1, done.
  - JUMP (11): pc_src=10, pc_write=1, done.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw (100011) or sw (101011).
  - DECODE -> EXECUTE for R-type (000000).
  - DECODE -> BRANCH for beq (000100).
  - DECODE -> ADDIEX for addi (001000).
  - DECODE -> JUMP for j (000010).
  - DECODE -> FETCH for any other opcode, with illegal_o=1 for that cycle. The instruction behaves as a NOP; the PC has already advanced.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB. EXECUTE -> ALUWB. ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all go to FETCH.
  - Encodings 12-15 are unreachable. If entered, they behave as FETCH-bound with all outputs 0.
- Latency in cycles, FETCH through the done state: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
- ALU decode:
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (sub).
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010 with no flag.
  - aluop 11 -> 010.
- beq: zero_i is used combinationally in BRANCH only. zero_i=0 leaves pc_en_o=0.

Decomposition:
- Package mips_pkg holds:
  - the state_t enum (4-bit, values as listed above);
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct localparams F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - alu_control localparams;
  - the aluop_t 2-bit encoding.
- Sub-module aludec (combinational): funct_i6 and aluop_i2 -> alu_control_o3. It is shared with the single-cycle decoder. The FSM stays in mips_mc_controller.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles -> state_o4=0, ir_write_o=1, pc_en_o=1, alu_src_b_o2=01, all write strobes except IR/PC = 0. Release -> state 1 on the next edge.
- lw (opcode 100011) -> states 0,1,2,3,4. mem_write_o stays 0, iord_o=1 in state 3, reg_write_o=1 and mem_to_reg_o=1 in state 4, instr_done_o pulses exactly once.
- R-type sub (funct 100010) -> states 0,1,6,7. alu_control_o3=110 in state 6, reg_dst_o=1 in state 7. sw -> states 0,1,2,5 with mem_write_o=1 only in state 5.
- beq in state 8: zero_i=1 -> pc_en_o=1, pc_src_o2=01; zero_i=0 -> pc_en_o=0. j -> state 11 with pc_src_o2=10, pc_en_o=1.
- Illegal opcode 111111 -> illegal_o=1 in the DECODE cycle, next state 0, no reg_write_o or mem_write_o pulse.
- Assert reset_ni low asynchronously mid-cycle while in state 5 (sw) -> state_o4=0 and mem_write_o=0 before the next clock edge.
